// File: rtl/booth_pkg.sv
// booth_pkg -- shared FSM encodings and Booth digit fields for the radix-4 multiplier. Rev 1.0
`default_nettype none

package booth_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic zero;
    logic two;
    logic neg;
  } booth_digit_t;

endpackage

`default_nettype wire

// File: rtl/booth_r4_recode.sv
// booth_r4_recode -- maps a 3-bit Booth window {q1,q0,q_1} to {zero, two, neg}. Rev 1.0
`default_nettype none

module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output logic [2:0] digit
);

  booth_digit_t d;

  always_comb begin
    d = '{zero: 1'b1, two: 1'b0, neg: 1'b0};
    case (window)
      3'b001, 3'b010: d = '{zero: 1'b0, two: 1'b0, neg: 1'b0};
      3'b011:         d = '{zero: 1'b0, two: 1'b1, neg: 1'b0};
      3'b100:         d = '{zero: 1'b0, two: 1'b1, neg: 1'b1};
      3'b101, 3'b110: d = '{zero: 1'b0, two: 1'b0, neg: 1'b1};
      default:        d = '{zero: 1'b1, two: 1'b0, neg: 1'b0};
    endcase
  end

  assign digit = d;

endmodule

`default_nettype wire

// File: rtl/booth_r4_mult_seq.sv
// booth_r4_mult_seq -- sequential radix-4 Booth multiplier, one digit per clock, go/busy/done. Rev 1.0
`default_nettype none

module booth_r4_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state
);

  localparam int ITERS = WIDTH / 2 + 1;
  localparam int XW    = WIDTH + 2;
  localparam int AW    = WIDTH + 3;
  localparam int CW    = $clog2(ITERS);

  logic [XW-1:0]       mreg;
  logic [XW-1:0]       qreg;
  logic                q1;
  logic [AW-1:0]       acc;
  logic [CW-1:0]       cnt;

  logic [2:0]          digit_bits;
  booth_digit_t        dig;
  logic [AW-1:0]       mx;
  logic [AW-1:0]       addend;
  logic [AW-1:0]       sum;
  logic [AW-1:0]       carry;
  logic [2*WIDTH+5:0]  sh;

  function automatic logic [XW-1:0] extend(input logic [WIDTH-1:0] x, input logic s);
    return {{2{s & x[WIDTH-1]}}, x};
  endfunction

  booth_r4_recode u_recode (
    .window (({qreg[1:0], q1})),
    .digit  (digit_bits)
  );

  assign dig = booth_digit_t'(digit_bits);

  // Negation is ~x plus a carry-in of one, folded into the ripple chain.
  assign mx     = dig.two ? {mreg, 1'b0} : {mreg[XW-1], mreg};
  assign addend = dig.zero ? '0 : (dig.neg ? ~mx : mx);
  assign carry[0] = dig.neg & ~dig.zero;

  genvar i;
  generate
    for (i = 0; i < AW; i++) begin : g_ripple
      assign sum[i] = acc[i] ^ addend[i] ^ carry[i];
      if (i < AW - 1) begin : g_carry
        assign carry[i+1] = (acc[i] & addend[i]) | (carry[i] & (acc[i] ^ addend[i]));
      end
    end
  endgenerate

  // {acc,Q,q_1} arithmetic shift right by two, using the freshly added acc.
  assign sh = {{2{sum[AW-1]}}, sum, qreg[XW-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mreg    <= '0;
      qreg    <= '0;
      q1      <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            mreg  <= extend(multiplicand, is_signed);
            qreg  <= extend(multiplier, is_signed);
            acc   <= '0;
            q1    <= 1'b0;
            cnt   <= CW'(ITERS - 1);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc  <= sh[2*WIDTH+5:WIDTH+3];
          qreg <= sh[WIDTH+2:1];
          q1   <= sh[0];
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            product <= sh[2*WIDTH:1];
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

`default_nettype wire
